tinyqv_mem_arbiter: RTL and testbench
=====================================

# tinyqv_mem_arbiter

Two-requester arbiter that shares the single nibble-serial memory port between the core's data path (load/store, requester 0) and instruction fetch (requester 1). It sits between the core/fetch unit and the QSPI memory controller. It latches one request at a time, issues a start pulse downstream and steers read and write nibbles to the owning requester. It also supports abort of an in-flight fetch on branch and optional anti-starvation of fetch.

## Interface
Parameters:
- STARVE_MAX, 3: consecutive data grants after which a pending fetch wins (used only with fairness enabled)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- d_valid  in  1  data request pending
- d_write  in  1  data request is a store
- d_addr  in  24  data byte address
- d_len  in  4  data transfer length in nibbles minus 1
- d_ready  out  1  data request accepted this cycle
- d_wdata  in  4  store nibble, must be valid while d_wreq is high
- d_wreq  out  1  arbiter consumes d_wdata this cycle
- d_rvalid  out  1  rdata is a load nibble for requester 0
- f_valid  in  1  fetch request pending
- f_addr  in  24  fetch address
- f_len  in  4  fetch length in nibbles minus 1
- f_ready  out  1  fetch request accepted this cycle
- f_abort  in  1  cancel the current fetch (branch taken)
- f_rvalid  out  1  rdata is an instruction nibble for requester 1
- rdata  out  4  read nibble, copy of mem_rdata
- mem_start  out  1  one-cycle transfer start pulse
- mem_write  out  1  registered transfer direction
- mem_addr  out  24  registered address
- mem_len  out  4  registered length minus 1
- mem_rdata  in  4  read nibble from memory controller
- mem_rvalid  in  1  mem_rdata valid
- mem_wdata  out  4  write nibble, equal to d_wdata
- mem_wready  in  1  memory controller consumes mem_wdata
- mem_stop  out  1  one-cycle abort pulse to memory controller
- mem_done  in  1  transfer complete pulse

## Operation
- States: IDLE, START, XFER.
- IDLE:
  - If d_valid and fetch does not win: assert d_ready (combinational), owner=0, latch d_write/d_addr/d_len, go to START.
  - Otherwise, if f_valid: assert f_ready, owner=1, mem_write=0, latch f_addr/f_len, go to START.
  - At most one ready per cycle.
  - Fetch wins when fairness is enabled, starve_cnt==STARVE_MAX and f_valid is high.
- START: mem_start=1 for exactly one cycle. remaining <= mem_len. Go to XFER.
- XFER, read (mem_write=0):
  - Each cycle with mem_rvalid: pulse d_rvalid or f_rvalid per owner; remaining decrements.
  - Nibbles arriving with remaining==0 already consumed are dropped (no rvalid).
- XFER, write:
  - d_wreq = mem_wready while nibbles remain; mem_wdata = d_wdata; remaining decrements on each transfer.
- XFER exits to IDLE on the cycle after mem_done.
- Abort:
  - f_abort while owner=1 in START or XFER: mem_stop=1 that cycle; f_rvalid is forced 0 from that cycle onward; next state is IDLE. The START pulse is also suppressed if the abort arrives in START.
  - f_abort in IDLE or while owner=0 is ignored.
- starve_cnt (fairness only):
  - Increments, saturating at STARVE_MAX, on a data grant while f_valid is high.
  - Clears on any fetch grant.
- remaining is 4-bit; length 16 nibbles is encoded as 4'hF. No wrap beyond zero.

## Timing
- Reset:
  - State IDLE; owner=0; starve_cnt=0; remaining=0.
  - mem_start, mem_stop, mem_write, d_ready, f_ready, d_wreq, d_rvalid and f_rvalid are all 0.
  - mem_addr and mem_len are 0.
- Reset mid-transfer returns to IDLE next edge with no mem_stop; the memory controller shares the reset.
- Grant latency:
  - ready in cycle N (IDLE), mem_start in N+1, first nibble no earlier than N+2.
- Back-to-back:
  - mem_done in cycle M, IDLE in M+1, next grant possible in M+1.
  - Minimum gap between mem_start pulses is 3 cycles.
- Simultaneous d_valid and f_valid: data wins unless the fairness override applies.
- mem_done and f_abort in the same cycle: mem_stop is still pulsed; result is IDLE next cycle.
- rdata, d_rvalid and f_rvalid are combinational from mem_rdata and mem_rvalid (zero latency).

## Configuration
- TINYQV_ARB_FAIRNESS_EN defined:
  - starve_cnt and the STARVE_MAX override are present.
- Undefined:
  - Strict data priority; starve_cnt is not built; STARVE_MAX is unused.

## Test plan
- Reset mid-XFER of a 8-nibble fetch -> all outputs 0 next cycle; a later f_valid is granted normally.
- d_valid and f_valid both high in IDLE -> d_ready=1, f_ready=0, mem_addr=d_addr, mem_start one cycle later.
- Data read with d_len=3, memory sends 4 nibbles A,B,C,D -> d_rvalid high 4 times with rdata A..D, f_rvalid never high. After mem_done: IDLE, and f_ready is possible the next cycle.
- Store with d_len=1, mem_wready high 2 cycles -> d_wreq pulses twice, mem_wdata follows d_wdata; a third mem_wready gives no d_wreq.
- Fetch with f_len=7, f_abort after 3 nibbles -> mem_stop one cycle, no further f_rvalid, IDLE next cycle; the pending d_valid is granted.
- Fairness build, STARVE_MAX=3, d_valid and f_valid held high -> 3 data grants, then f_ready. Non-fairness build -> f_ready never asserts while d_valid is held.

Source files
------------

// File: rtl/tinyqv_mem_arbiter_if.sv
// Bundle of the data-path, fetch and memory-controller signals around tinyqv_mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/memory environment.
interface tinyqv_mem_arbiter_if;
  logic        d_valid;
  logic        d_write;
  logic [23:0] d_addr;
  logic [3:0]  d_len;
  logic        d_ready;
  logic [3:0]  d_wdata;
  logic        d_wreq;
  logic        d_rvalid;
  logic        f_valid;
  logic [23:0] f_addr;
  logic [3:0]  f_len;
  logic        f_ready;
  logic        f_abort;
  logic        f_rvalid;
  logic [3:0]  rdata;
  logic        mem_start;
  logic        mem_write;
  logic [23:0] mem_addr;
  logic [3:0]  mem_len;
  logic [3:0]  mem_rdata;
  logic        mem_rvalid;
  logic [3:0]  mem_wdata;
  logic        mem_wready;
  logic        mem_stop;
  logic        mem_done;

  modport slave (
    input  d_valid, d_write, d_addr, d_len, d_wdata,
    input  f_valid, f_addr, f_len, f_abort,
    input  mem_rdata, mem_rvalid, mem_wready, mem_done,
    output d_ready, d_wreq, d_rvalid, f_ready, f_rvalid, rdata,
    output mem_start, mem_write, mem_addr, mem_len, mem_wdata, mem_stop
  );

  modport master (
    output d_valid, d_write, d_addr, d_len, d_wdata,
    output f_valid, f_addr, f_len, f_abort,
    output mem_rdata, mem_rvalid, mem_wready, mem_done,
    input  d_ready, d_wreq, d_rvalid, f_ready, f_rvalid, rdata,
    input  mem_start, mem_write, mem_addr, mem_len, mem_wdata, mem_stop
  );
endinterface

// File: rtl/tinyqv_mem_arbiter.sv
// Shares the nibble-serial memory port between data (requester 0) and fetch (requester 1).
// Define TINYQV_ARB_FAIRNESS_EN to let a starved fetch win after STARVE_MAX data grants.
module tinyqv_mem_arbiter #(
  parameter int STARVE_MAX = 3
) (
  input logic               clk,
  input logic               rstn,
  tinyqv_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, XFER} state_t;

  state_t      state_reg, state_next;
  logic        owner_reg;
  logic        mem_write_reg;
  logic [23:0] mem_addr_reg;
  logic [3:0]  mem_len_reg;
  logic [3:0]  remaining_reg;
  logic        exhausted_reg;

  logic fetch_wins;
  logic grant_d, grant_f;
  logic abort_hit;
  logic take_nibble, take_wdata;
  logic start_pulse;
  logic d_rvalid_c, f_rvalid_c, d_wreq_c;

`ifdef TINYQV_ARB_FAIRNESS_EN
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rstn)
      starve_cnt_reg <= '0;
    else if (grant_f)
      starve_cnt_reg <= '0;
    else if (grant_d && bus.f_valid && starve_cnt_reg != SW'(STARVE_MAX))
      starve_cnt_reg <= starve_cnt_reg + 1'b1;
  end

  assign fetch_wins = bus.f_valid && (starve_cnt_reg == SW'(STARVE_MAX));
`else
  // Strict data priority; STARVE_MAX only matters in the fairness build.
  assign fetch_wins = 1'b0 && (STARVE_MAX < 0);
`endif

  always_comb begin
    state_next  = state_reg;
    grant_d     = 1'b0;
    grant_f     = 1'b0;
    start_pulse = 1'b0;
    take_nibble = 1'b0;
    take_wdata  = 1'b0;
    d_rvalid_c  = 1'b0;
    f_rvalid_c  = 1'b0;
    d_wreq_c    = 1'b0;
    abort_hit   = owner_reg && bus.f_abort && (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
        if (rstn) begin
          if (bus.d_valid && !fetch_wins)
            grant_d = 1'b1;
          else if (bus.f_valid)
            grant_f = 1'b1;
        end
        if (grant_d || grant_f)
          state_next = START;
      end
      START: begin
        start_pulse = !abort_hit;
        state_next  = abort_hit ? IDLE : XFER;
      end
      XFER: begin
        // Once the requested length is used up, extra beats are swallowed silently.
        if (mem_write_reg) begin
          take_wdata = bus.mem_wready && !exhausted_reg;
          d_wreq_c   = take_wdata;
        end else begin
          take_nibble = bus.mem_rvalid && !exhausted_reg && !abort_hit;
          d_rvalid_c  = take_nibble && !owner_reg;
          f_rvalid_c  = take_nibble && owner_reg;
        end
        if (abort_hit || bus.mem_done)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      owner_reg     <= 1'b0;
      mem_write_reg <= 1'b0;
      mem_addr_reg  <= '0;
      mem_len_reg   <= '0;
      remaining_reg <= '0;
      exhausted_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (grant_d) begin
        owner_reg     <= 1'b0;
        mem_write_reg <= bus.d_write;
        mem_addr_reg  <= bus.d_addr;
        mem_len_reg   <= bus.d_len;
      end else if (grant_f) begin
        owner_reg     <= 1'b1;
        mem_write_reg <= 1'b0;
        mem_addr_reg  <= bus.f_addr;
        mem_len_reg   <= bus.f_len;
      end
      if (state_reg == START) begin
        remaining_reg <= mem_len_reg;
        exhausted_reg <= 1'b0;
      end else if (take_nibble || take_wdata) begin
        if (remaining_reg == 4'd0)
          exhausted_reg <= 1'b1;
        else
          remaining_reg <= remaining_reg - 4'd1;
      end
    end
  end

  assign bus.d_ready   = grant_d;
  assign bus.f_ready   = grant_f;
  assign bus.d_rvalid  = d_rvalid_c;
  assign bus.f_rvalid  = f_rvalid_c;
  assign bus.d_wreq    = d_wreq_c;
  assign bus.rdata     = bus.mem_rdata;
  assign bus.mem_wdata = bus.d_wdata;
  assign bus.mem_start = start_pulse;
  assign bus.mem_stop  = abort_hit;
  assign bus.mem_write = mem_write_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_len   = mem_len_reg;
endmodule

// File: tb/tb_tinyqv_mem_arbiter.sv
// Cycle-by-cycle vector bench for tinyqv_mem_arbiter, plus a grant-ordering sequence
// whose expectation depends on TINYQV_ARB_FAIRNESS_EN.
module tb_tinyqv_mem_arbiter;
  localparam logic [23:0] DA = 24'h123456;
  localparam logic [23:0] FA = 24'hABCDE0;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  tinyqv_mem_arbiter_if bus ();

  tinyqv_mem_arbiter #(.STARVE_MAX(3)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic        rstn, dv, dw;
    logic [3:0]  dlen;
    logic        fv, fab, rv;
    logic [3:0]  rd;
    logic        wr;
    logic [3:0]  wd;
    logic        done;
    logic [7:0]  exp_o;   // d_ready f_ready mem_start mem_stop d_rvalid f_rvalid d_wreq mem_write
    logic [23:0] exp_addr;
    logic [3:0]  exp_len;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(input int rs, dv, dw, dlen, fv, fab, rv, rd, wr, wd, done,
                              input int o, a, l);
    vec_t v;
    v.rstn = 1'(rs); v.dv = 1'(dv); v.dw = 1'(dw); v.dlen = 4'(dlen);
    v.fv = 1'(fv); v.fab = 1'(fab); v.rv = 1'(rv); v.rd = 4'(rd);
    v.wr = 1'(wr); v.wd = 4'(wd); v.done = 1'(done);
    v.exp_o = 8'(o); v.exp_addr = 24'(a); v.exp_len = 4'(l);
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic logic [7:0] obs();
    return {bus.d_ready, bus.f_ready, bus.mem_start, bus.mem_stop,
            bus.d_rvalid, bus.f_rvalid, bus.d_wreq, bus.mem_write};
  endfunction

  initial begin
    bus.d_valid = 0; bus.d_write = 0; bus.d_addr = DA; bus.d_len = 4'd3; bus.d_wdata = 0;
    bus.f_valid = 0; bus.f_addr = FA; bus.f_len = 4'd7; bus.f_abort = 0;
    bus.mem_rdata = 0; bus.mem_rvalid = 0; bus.mem_wready = 0; bus.mem_done = 0;

    //          rs dv dw dl fv ab rv rd   wr wd   dn  outs          addr len
    vecs.push_back(mk(0, 0, 0, 3, 0, 0, 0, 0,   0, 0,   0, 8'b00000000, 0,  0)); // reset
    vecs.push_back(mk(1, 1, 0, 3, 1, 0, 0, 0,   0, 0,   0, 8'b10000000, 0,  0)); // both valid: data wins
    vecs.push_back(mk(1, 0, 0, 3, 1, 0, 0, 0,   0, 0,   0, 8'b00100000, DA, 3)); // start pulse
    vecs.push_back(mk(1, 0, 0, 3, 0, 0, 1, 'hA, 0, 0,   0, 8'b00001000, DA, 3));
    vecs.push_back(mk(1, 0, 0, 3, 0, 1, 1, 'hB, 0, 0,   0, 8'b00001000, DA, 3)); // abort ignored for data
    vecs.push_back(mk(1, 0, 0, 3, 0, 0, 1, 'hC, 0, 0,   0, 8'b00001000, DA, 3));
    vecs.push_back(mk(1, 0, 0, 3, 0, 0, 1, 'hD, 0, 0,   0, 8'b00001000, DA, 3));
    vecs.push_back(mk(1, 0, 0, 3, 0, 0, 1, 'hE, 0, 0,   1, 8'b00000000, DA, 3)); // extra nibble dropped
    vecs.push_back(mk(1, 0, 0, 3, 1, 0, 0, 0,   0, 0,   0, 8'b01000000, DA, 3)); // fetch grant right after done
    vecs.push_back(mk(1, 0, 0, 3, 0, 0, 0, 0,   0, 0,   0, 8'b00100000, FA, 7));
    vecs.push_back(mk(1, 0, 0, 3, 0, 0, 1, 'h1, 0, 0,   0, 8'b00000100, FA, 7));
    vecs.push_back(mk(1, 0, 0, 3, 0, 0, 1, 'h2, 0, 0,   0, 8'b00000100, FA, 7));
    vecs.push_back(mk(1, 0, 0, 3, 0, 0, 1, 'h3, 0, 0,   0, 8'b00000100, FA, 7));
    vecs.push_back(mk(1, 1, 1, 1, 0, 1, 1, 'h4, 0, 0,   0, 8'b00010000, FA, 7)); // fetch abort in XFER
    vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0,   0, 0,   0, 8'b10000000, FA, 7)); // pending store granted
    vecs.push_back(mk(1, 0, 0, 3, 0, 0, 0, 0,   0, 0,   0, 8'b00100001, DA, 1));
    vecs.push_back(mk(1, 0, 0, 3, 0, 0, 0, 0,   1, 'h5, 0, 8'b00000011, DA, 1));
    vecs.push_back(mk(1, 0, 0, 3, 0, 0, 0, 0,   1, 'hA, 0, 8'b00000011, DA, 1));
    vecs.push_back(mk(1, 0, 0, 3, 0, 0, 0, 0,   1, 'hC, 0, 8'b00000001, DA, 1)); // third wready: no d_wreq
    vecs.push_back(mk(1, 0, 0, 3, 0, 0, 0, 0,   0, 0,   1, 8'b00000001, DA, 1));
    vecs.push_back(mk(1, 0, 0, 3, 0, 0, 0, 0,   0, 0,   0, 8'b00000001, DA, 1));
    vecs.push_back(mk(1, 0, 0, 3, 1, 0, 0, 0,   0, 0,   0, 8'b01000001, DA, 1));
    vecs.push_back(mk(1, 0, 0, 3, 0, 1, 0, 0,   0, 0,   0, 8'b00010000, FA, 7)); // abort in START
    vecs.push_back(mk(1, 0, 0, 3, 0, 1, 0, 0,   0, 0,   0, 8'b00000000, FA, 7)); // abort in IDLE ignored
    vecs.push_back(mk(1, 0, 0, 3, 1, 0, 0, 0,   0, 0,   0, 8'b01000000, FA, 7));
    vecs.push_back(mk(1, 0, 0, 3, 0, 0, 0, 0,   0, 0,   0, 8'b00100000, FA, 7));
    vecs.push_back(mk(1, 0, 0, 3, 0, 0, 1, 'h6, 0, 0,   0, 8'b00000100, FA, 7));
    vecs.push_back(mk(0, 0, 0, 3, 0, 0, 0, 0,   0, 0,   0, 8'b00000000, FA, 7)); // reset mid-XFER
    vecs.push_back(mk(1, 0, 0, 3, 0, 0, 1, 'h7, 0, 0,   0, 8'b00000000, 0,  0));
    vecs.push_back(mk(1, 0, 0, 3, 1, 0, 0, 0,   0, 0,   0, 8'b01000000, 0,  0));
    vecs.push_back(mk(1, 0, 0, 3, 0, 0, 0, 0,   0, 0,   0, 8'b00100000, FA, 7));
    vecs.push_back(mk(1, 0, 0, 3, 0, 1, 0, 0,   0, 0,   1, 8'b00010000, FA, 7)); // done with abort
    vecs.push_back(mk(1, 0, 0, 3, 0, 0, 0, 0,   0, 0,   0, 8'b00000000, FA, 7));

    foreach (vecs[i]) begin
      @(negedge clk);
      rstn           = vecs[i].rstn;
      bus.d_valid    = vecs[i].dv;
      bus.d_write    = vecs[i].dw;
      bus.d_len      = vecs[i].dlen;
      bus.f_valid    = vecs[i].fv;
      bus.f_abort    = vecs[i].fab;
      bus.mem_rvalid = vecs[i].rv;
      bus.mem_rdata  = vecs[i].rd;
      bus.mem_wready = vecs[i].wr;
      bus.d_wdata    = vecs[i].wd;
      bus.mem_done   = vecs[i].done;
      #1;
      check("outs", i, 32'(obs()), 32'(vecs[i].exp_o));
      check("mem_addr", i, 32'(bus.mem_addr), 32'(vecs[i].exp_addr));
      check("mem_len", i, 32'(bus.mem_len), 32'(vecs[i].exp_len));
      check("rdata", i, 32'(bus.rdata), 32'(vecs[i].rd));
      check("mem_wdata", i, 32'(bus.mem_wdata), 32'(vecs[i].wd));
      $display("[TB] row %0d outs=%b addr=%h len=%0d", i, obs(), bus.mem_addr, bus.mem_len);
    end

    // Grant ordering with both requesters held high; each transfer completes right after start.
    begin
      logic saw_start;
      int   g;
      logic exp_fetch;
      saw_start = 1'b0;
      g = 0;
      @(negedge clk);
      rstn = 1'b0;
      bus.f_abort = 0; bus.mem_rvalid = 0; bus.mem_wready = 0; bus.mem_done = 0; bus.d_write = 0;
      for (int c = 0; c < 60 && g < 6; c++) begin
        @(negedge clk);
        rstn = 1'b1;
        bus.d_valid  = 1'b1;
        bus.f_valid  = 1'b1;
        bus.mem_done = saw_start;
        #1;
        saw_start = bus.mem_start;
        if (bus.d_ready || bus.f_ready) begin
`ifdef TINYQV_ARB_FAIRNESS_EN
          exp_fetch = (g == 3);
`else
          exp_fetch = 1'b0;
`endif
          check("grant_order", g, {30'd0, bus.d_ready, bus.f_ready}, {30'd0, !exp_fetch, exp_fetch});
          $display("[TB] grant %0d d_ready=%b f_ready=%b", g, bus.d_ready, bus.f_ready);
          g++;
        end
      end
      check("grant_count", 0, 32'(g), 32'd6);
    end

    @(negedge clk);
    bus.d_valid = 0; bus.f_valid = 0; bus.mem_done = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
